// File: rtl/add_seq_ctrl_pkg.sv
// Shared types and constants for the digit-serial adder controller.
package add_seq_ctrl_pkg;

  localparam int DIGIT_W = 4;
  localparam int NIB_MIN = 1;
  localparam int NIB_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq_ctrl_add4_core.sv
// Combinational 4-bit ripple-carry adder shared by every digit step.
module add4_core
  import add_seq_ctrl_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co
);

  logic w_c;

  // NOTE: every variable written in always_comb gets a value before any
  // conditional or loop, otherwise synthesis infers a latch.
  always_comb begin
    w_c = ci;
    s   = '0;
    for (int i = 0; i < DIGIT_W; i++) begin
      s[i] = a[i] ^ b[i] ^ w_c;
      w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    co = w_c;
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Digit-serial W-bit adder: one shared 4-bit adder stepped LSD first, with
// a valid/ready handshake on both operand and result sides.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIGIT_W*NIB-1:0] A,
  input  logic [DIGIT_W*NIB-1:0] B,
  input  logic                   Cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIGIT_W*NIB-1:0] S,
  output logic                   Cout,
  output logic                   Ovf,
  output logic                   busy
);

  localparam int W     = DIGIT_W * NIB;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NIB - 1);

  if (NIB < NIB_MIN || NIB > NIB_MAX) begin : g_bad_nib
    $error("add_seq_ctrl: NIB out of range");
  end

  state_t             r_state;
  logic [CNT_W-1:0]   r_step;
  logic               r_carry;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_s;
  logic               r_cout;
  logic               r_ovf;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_in_ready;

  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic [DIGIT_W-1:0] w_sum;
  logic               w_co;

  // Select the current digit of the captured operands.
  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int i = 0; i < NIB; i++) begin
      if (r_step == CNT_W'(i)) begin
        w_a_dig = r_a[DIGIT_W*i +: DIGIT_W];
        w_b_dig = r_b[DIGIT_W*i +: DIGIT_W];
      end
    end
  end

  add4_core u_add4_core (
    .a  (w_a_dig),
    .b  (w_b_dig),
    .ci (r_carry),
    .s  (w_sum),
    .co (w_co)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: all state here is small flop storage, so it is all reset; there is
  // no memory array that would need to be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= A;
            r_b        <= B;
            r_carry    <= Cin;
            r_step     <= '0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (r_step == CNT_W'(i)) r_s[DIGIT_W*i +: DIGIT_W] <= w_sum;
          end
          r_carry <= w_co;
          r_step  <= r_step + 1'b1;
          if (r_step == LAST_STEP) begin
            // Top digit sum bit is the new sign of S.
            r_cout      <= w_co;
            r_ovf       <= (r_a[W-1] == r_b[W-1]) && (w_sum[DIGIT_W-1] != r_a[W-1]);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign S         = r_s;
  assign Cout      = r_cout;
  assign Ovf       = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed and randomized bench for add_seq_ctrl with NIB=4 (16-bit operands).
module tb_add_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         Ovf;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int n_done = 0;

  add_seq_ctrl #(.NIB(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)   n_acc++;
      if (out_valid && out_ready) n_done++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    in_valid = 1'b1;
    A        = a;
    B        = b;
    Cin      = cin;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts rising edges until out_valid is seen, bounded at 20.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic consume(input int delay);
    repeat (delay) begin
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    A         = 16'h0001;
    B         = 16'h0001;
    Cin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({S, Cout, Ovf, out_valid, busy} !== {16'h0000, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_outputs: got S=%h Cout=%b Ovf=%b out_valid=%b busy=%b, want all 0",
               S, Cout, Ovf, out_valid, busy);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({busy, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL first_accept: got busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready);
    end
    wait_done(lat);
    n_cmp++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL latency_first: got %0d edges want 4", lat);
    end
    n_cmp++;
    if ({S, Cout, Ovf} !== {16'h0002, 2'b00}) begin
      n_fail++;
      $display("FAIL add_1_1: got S=%h Cout=%b Ovf=%b want S=0002 Cout=0 Ovf=0", S, Cout, Ovf);
    end
    consume(0);
  endtask

  task automatic test_vectors;
    logic [W-1:0] va [3]  = '{16'hFFFF, 16'h7FFF, 16'h8000};
    logic [W-1:0] vb [3]  = '{16'h0000, 16'h0001, 16'h8000};
    logic         vc [3]  = '{1'b1, 1'b0, 1'b0};
    logic [W-1:0] es [3]  = '{16'h0000, 16'h8000, 16'h0000};
    logic         eco [3] = '{1'b1, 1'b0, 1'b1};
    logic         eov [3] = '{1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], vc[i]);
      wait_done(lat);
      n_cmp++;
      if (lat !== 4) begin
        n_fail++;
        $display("FAIL latency_vec%0d: got %0d edges want 4", i, lat);
      end
      n_cmp++;
      if ({S, Cout, Ovf} !== {es[i], eco[i], eov[i]}) begin
        n_fail++;
        $display("FAIL vec%0d %h+%h+%b: got S=%h Cout=%b Ovf=%b want S=%h Cout=%b Ovf=%b",
                 i, va[i], vb[i], vc[i], S, Cout, Ovf, es[i], eco[i], eov[i]);
      end
      consume(1);
    end
  endtask

  task automatic test_hold_done;
    int lat;
    start_op(16'h1234, 16'h0FF0, 1'b1);
    wait_done(lat);
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      A        = ~A;
      B        = B ^ 16'hA5A5;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({S, Cout, Ovf, out_valid, in_ready} !== {16'h2225, 2'b00, 2'b10}) begin
        n_fail++;
        $display("FAIL hold_done%0d: got S=%h Cout=%b Ovf=%b out_valid=%b in_ready=%b want S=2225 0 0 1 0",
                 i, S, Cout, Ovf, out_valid, in_ready);
      end
    end
    in_valid  = 1'b1;
    A         = 16'h0001;
    B         = 16'h0002;
    Cin       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL release_no_accept: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_after_release: got busy=%b want 1", busy);
    end
    wait_done(lat);
    n_cmp++;
    if ({S, lat} !== {16'h0003, 32'd4}) begin
      n_fail++;
      $display("FAIL post_release_op: got S=%h lat=%0d want S=0003 lat=4", S, lat);
    end
    consume(0);
  endtask

  task automatic test_reset_mid;
    int   lat;
    logic seen_valid = 1'b0;
    start_op(16'h1234, 16'h4321, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({S, Cout, Ovf, out_valid, busy} !== {16'h0000, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_mid: got S=%h Cout=%b Ovf=%b out_valid=%b busy=%b want all 0",
               S, Cout, Ovf, out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_cmp++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_valid: got out_valid seen=%b want 0", seen_valid);
    end
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_done(lat);
    n_cmp++;
    if ({S, Cout, Ovf, lat} !== {16'h5555, 2'b00, 32'd4}) begin
      n_fail++;
      $display("FAIL after_reset_op: got S=%h Cout=%b Ovf=%b lat=%0d want S=5555 0 0 4",
               S, Cout, Ovf, lat);
    end
    consume(0);
  endtask

  task automatic test_back_to_back;
    int           lat;
    logic [W-1:0] a, b;
    logic         c, eov;
    logic [W:0]   exp_sum;
    int           bad = 0;
    n_acc  = 0;
    n_done = 0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        @(negedge clk);
      end
      a       = W'($urandom);
      b       = W'($urandom);
      c       = 1'($urandom);
      exp_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      eov     = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);
      start_op(a, b, c);
      wait_done(lat);
      n_cmp++;
      if ({Cout, S, Ovf, lat} !== {exp_sum, eov, 32'd4}) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL rand%0d %h+%h+%b: got Cout=%b S=%h Ovf=%b lat=%0d want Cout=%b S=%h Ovf=%b lat=4",
                   i, a, b, c, Cout, S, Ovf, lat, exp_sum[W], exp_sum[W-1:0], eov);
        bad++;
      end
      consume($urandom_range(0, 2));
    end
    n_cmp++;
    if (n_acc !== 1000 || n_done !== 1000) begin
      n_fail++;
      $display("FAIL handshake_count: got accepted=%0d completed=%0d want 1000 1000", n_acc, n_done);
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_hold_done;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
